// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a single-entry valid/ready holding register.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_rx_byte #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  // Bit period must be at least 4 clocks for the half-bit start check to work.
  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          deliver, deliver_n;
  logic          ferr_n;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver state, bit timing, shift register and stop-bit result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      deliver   <= deliver_n;
      frame_err <= ferr_n;
    end
  end

  // Next-state logic: start is re-checked mid-bit, data/stop sampled mid-bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    deliver_n = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (rxs) state_n = IDLE;
      end
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          if (!rxs) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n        = '0;
          shift_n[idx] = rxs;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (rxs) begin
            deliver_n = 1'b1;
            state_n   = IDLE;  // mid-stop: ready for a back-to-back start
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;  // line may be in break; wait for high
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  // Holding register: load on delivery unless full and not being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: vector table, corner sequences, random bytes.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  localparam int CPB = 16;

  uart_rx_byte #(.CLOCK_RATE(1600), .BAUD_RATE(100)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observed behaviour, gathered on the falling edge.
  logic [7:0] got[$];
  int ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, vcyc = 0;
  logic pv = 1'b0;

  always @(negedge clk) begin
    if (valid && !pv) got.push_back(data);
    if (valid) vcyc++;
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
    pv = valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    tick(CPB * n);
  endtask

  // Bounded wait for one received byte, then compare it.
  task automatic wait_byte(input string name, input logic [7:0] exp);
    int t = 0;
    while (got.size() == 0 && t < 64) begin
      tick(1);
      t++;
    end
    if (got.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no byte expected %0h", name, exp);
    end else begin
      chk(name, got.pop_front(), exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_q[$];

  initial begin
    int f0, o0, v0;
    logic [7:0] r;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1'b0};

    rx = 1'b1; ready = 1'b1; rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    tick(1);
    idle_bits(2);

    // Table: single frames with ready held high.
    foreach (vecs[k]) begin
      f0 = ferr_cnt; v0 = vcyc;
      send_frame(vecs[k].d, vecs[k].stop);
      idle_bits(2);
      if (!vecs[k].exp_ferr) begin
        wait_byte($sformatf("vec%0d_data", k), vecs[k].exp_d);
        chk($sformatf("vec%0d_vcyc", k), vcyc - v0, 1);
      end else begin
        chk($sformatf("vec%0d_nobyte", k), got.size(), 0);
      end
      chk($sformatf("vec%0d_ferr", k), ferr_cnt - f0, {31'd0, vecs[k].exp_ferr});
    end

    // Short low glitch is rejected, next frame still decodes.
    f0 = ferr_cnt;
    rx = 1'b0; tick(4); rx = 1'b1;
    idle_bits(2);
    chk("glitch_nobyte", got.size(), 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1);
    idle_bits(2);
    wait_byte("glitch_next", 8'h3C);

    // Overrun: second byte dropped while first is held.
    ready = 1'b0; o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b1);
    idle_bits(2);
    chk("ovr_count", ovr_cnt - o0, 1);
    chk("ovr_nbytes", got.size(), 1);
    if (got.size() > 0) chk("ovr_first", got.pop_front(), 8'h11);
    @(negedge clk);
    chk("ovr_valid_held", valid, 1);
    chk("ovr_data_held", data, 8'h11);
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drain_valid", valid, 0);
    chk("drain_data", data, 8'h11);
    tick(1);
    idle_bits(1);

    // Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(2);
    wait_byte("b2b_first", 8'h00);
    wait_byte("b2b_second", 8'hFF);

    // Reset in the middle of bit 3 of 0xFF aborts the frame silently.
    f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1; tick(8);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(CPB - 9);
    for (int i = 4; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(10);
    chk("abort_nobyte", got.size(), 0);
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    wait_byte("abort_next", 8'h81);
    chk("abort_ferr", ferr_cnt - f0, 0);

    // Random bytes against the byte-stream model (good frames in, same bytes out).
    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom_range(0, 255));
      exp_q.push_back(r);
      send_frame(r, 1'b1);
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(2);
    chk("rand_count", got.size(), exp_q.size());
    while (exp_q.size() > 0 && got.size() > 0)
      chk("rand_byte", got.pop_front(), exp_q.pop_front());

    chk("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
